// File: rtl/alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_ctrl
//  Description : Round-robin arbiter that shares one combinational ALU between
//                two valid/ready requesters, holds the operands for a settle
//                interval, captures result and flags, and returns them on a
//                tagged valid/ready response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter_ctrl #(
    parameter int N_BITS        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [N_BITS-1:0]     req0_a,
    input  logic [N_BITS-1:0]     req0_b,
    input  logic [3:0]            req0_op,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [N_BITS-1:0]     req1_a,
    input  logic [N_BITS-1:0]     req1_b,
    input  logic [3:0]            req1_op,

    output logic [N_BITS-1:0]     alu_a,
    output logic [N_BITS-1:0]     alu_b,
    output logic [3:0]            alu_op,
    input  logic [2*N_BITS-1:0]   alu_result,
    input  logic                  alu_n,
    input  logic                  alu_z,
    input  logic                  alu_c,
    input  logic                  alu_v,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*N_BITS-1:0]   rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_id,
    output logic                  rsp_err,
    output logic                  busy
);

    // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
    localparam int c_CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_rr_ptr;
    logic [c_CW-1:0]        r_cnt;
    logic [N_BITS-1:0]      r_alu_a;
    logic [N_BITS-1:0]      r_alu_b;
    logic [3:0]             r_alu_op;
    logic [2*N_BITS-1:0]    r_rsp_result;
    logic [3:0]             r_rsp_flags;
    logic                   r_rsp_id;
    logic                   r_rsp_err;

    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_grant;
    logic                   w_id;
    logic [N_BITS-1:0]      w_a;
    logic [N_BITS-1:0]      w_b;
    logic [3:0]             w_op;
    logic                   w_op_err;
    logic                   w_cnt_zero;

    // Round-robin choice: a lone request wins; on contention rr_ptr decides.
    always_comb begin
        w_gnt0   = req0_valid && (!req1_valid || !r_rr_ptr);
        w_gnt1   = req1_valid && (!req0_valid ||  r_rr_ptr);
        w_grant  = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);
        w_id     = w_gnt1;
        w_a      = w_id ? req1_a  : req0_a;
        w_b      = w_id ? req1_b  : req0_b;
        w_op     = w_id ? req1_op : req0_op;
        // Undefined opcodes and divide/modulo by zero never reach the ALU.
        w_op_err = (w_op > 4'b1001) ||
                   (((w_op == 4'b0011) || (w_op == 4'b0100)) && (w_b == '0));
        w_cnt_zero = (r_cnt == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req0_ready = w_gnt0;
                req1_ready = w_gnt1;
                if (w_grant) begin
                    w_next = w_op_err ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, settle counter, result capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= 1'b0;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_rsp_id <= w_id;
                        r_rr_ptr <= ~w_id;
                        if (w_op_err) begin
                            // ALU inputs are left untouched for a rejected op.
                            r_rsp_result <= '0;
                            r_rsp_flags  <= '0;
                            r_rsp_err    <= 1'b1;
                        end else begin
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                            r_alu_op <= w_op;
                            r_cnt    <= c_CNT_LOAD;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_cnt_zero) begin
                        r_rsp_result <= alu_result;
                        r_rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
                        r_rsp_err    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_id     = r_rsp_id;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter_ctrl
//  Description : Self-checking bench for alu_arbiter_ctrl with a behavioural
//                ALU attached and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter_ctrl;

    localparam int N = 4;
    localparam int S = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [3:0]     req0_op, req1_op;
    logic [N-1:0]   alu_a, alu_b;
    logic [3:0]     alu_op;
    logic [2*N-1:0] alu_result;
    logic           alu_n, alu_z, alu_c, alu_v;
    logic           rsp_valid, rsp_ready;
    logic [2*N-1:0] rsp_result;
    logic [3:0]     rsp_flags;
    logic           rsp_id, rsp_err, busy;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.N_BITS(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU: returns {N,Z,C,V,result[7:0]}.
    function automatic logic [11:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
        logic [7:0] r;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                r = {4'b0, a} + {4'b0, b};
                c = r[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                r = {4'b0, a} - {4'b0, b};
                c = (a < b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2: r = {4'b0, a} * {4'b0, b};
            4'd3: r = (b == 0) ? 8'hFF : {4'b0, a / b};
            4'd4: r = (b == 0) ? {4'b0, a} : {4'b0, a % b};
            4'd5: r = {4'b0, a & b};
            4'd6: r = {4'b0, a | b};
            4'd7: r = {4'b0, a ^ b};
            4'd8: r = {4'b0, a} << b;
            4'd9: r = {4'b0, a} >> b;
            default: r = 8'h00;
        endcase
        return {r[7], (r == 8'h00), c, v, r};
    endfunction

    assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_fn(alu_a, alu_b, alu_op);

    // Expected response {err, flags, result} for a request.
    function automatic logic [12:0] exp_rsp(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] op);
        if ((op > 4'd9) || (((op == 4'd3) || (op == 4'd4)) && (b == 4'd0)))
            return {1'b1, 12'h000};
        return {1'b0, alu_fn(a, b, op)};
    endfunction

    typedef struct {
        logic        id;
        logic [3:0]  a, b, op;
        logic [12:0] exp;
        int          t;
    } txn_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         hcnt     = 0;
    txn_t       pend[$];
    logic       served_q[$];
    logic       ptr      = 1'b0;
    logic [3:0] last_op  = 4'd0;
    logic [7:0] last_res;
    logic [3:0] last_flags;
    logic       last_id, last_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk(tag, {req0_ready, req1_ready, alu_a, alu_b, alu_op, rsp_valid,
                  rsp_result, rsp_flags, rsp_id, rsp_err, busy}, 32'd0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Drives cycles until nrsp responses complete. Grants are predicted from
    // the round-robin rule; responses are checked for latency, content and
    // stability. mode: 0 ready high, 1 random ready, 2 ready low for 5 cycles.
    task automatic run(input int nrsp, input int mode);
        int          got, guard;
        bit          drop0, drop1, have;
        logic        w;
        logic [13:0] cur, held;
        txn_t        t;
        got = 0; guard = 0; have = 0; held = '0;
        while ((got < nrsp) && (guard < 200)) begin
            drop0 = 0; drop1 = 0;
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = (hcnt >= 5);
            endcase
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                w = (req0_valid && req1_valid) ? ptr : req1_valid;
                chk("grant_id", req1_ready, w);
                chk("ready_onehot", req0_ready & req1_ready, 0);
                chk("one_in_flight", pend.size(), 0);
                t.id  = req1_ready;
                t.a   = t.id ? req1_a  : req0_a;
                t.b   = t.id ? req1_b  : req0_b;
                t.op  = t.id ? req1_op : req0_op;
                t.exp = exp_rsp(t.a, t.b, t.op);
                t.t   = cyc;
                pend.push_back(t);
                ptr = ~t.id;
                if (t.id) drop1 = 1; else drop0 = 1;
            end
            if (rsp_valid) begin
                cur = {rsp_id, rsp_err, rsp_flags, rsp_result};
                hcnt++;
                if (pend.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else if (!have) begin
                    t = pend[0];
                    chk("latency", cyc - t.t, t.exp[12] ? 1 : S + 1);
                    chk("rsp_id", rsp_id, t.id);
                    chk("rsp_err", rsp_err, t.exp[12]);
                    chk("rsp_flags", rsp_flags, t.exp[11:8]);
                    chk("rsp_result", rsp_result, t.exp[7:0]);
                    if (t.exp[12]) begin
                        chk("alu_op_kept", alu_op, last_op);
                    end else begin
                        chk("alu_a", alu_a, t.a);
                        chk("alu_b", alu_b, t.b);
                        chk("alu_op", alu_op, t.op);
                        last_op = t.op;
                    end
                end else begin
                    chk("rsp_stable", cur, held);
                end
                held = cur;
                have = 1;
                if (rsp_ready && (pend.size() > 0)) begin
                    last_res   = rsp_result;
                    last_flags = rsp_flags;
                    last_id    = rsp_id;
                    last_err   = rsp_err;
                    served_q.push_back(rsp_id);
                    void'(pend.pop_front());
                    got++;
                    have = 0;
                end
            end
            @(posedge clk);
            #1;
            if (drop0) req0_valid = 1'b0;
            if (drop1) req1_valid = 1'b0;
            guard++;
        end
        chk("run_complete", got, nrsp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ptr = 1'b0;
        last_op = 4'd0;
        pend.delete();
    endtask

    // Directed steps followed by randomized traffic.
    initial begin
        bit seen;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // MUL 15*15 from requester 0
        req0_a = 4'hF; req0_b = 4'hF; req0_op = 4'd2; req0_valid = 1;
        run(1, 0);
        chk("t1_result", last_res, 8'hE1);
        chk("t1_id", last_id, 0);
        chk("t1_err", last_err, 0);

        // Contention after reset: req0 first, then req1
        do_reset();
        served_q.delete();
        req0_a = 4'hC; req0_b = 4'hA; req0_op = 4'd5; req0_valid = 1;
        req1_a = 4'hF; req1_b = 4'h0; req1_op = 4'd6; req1_valid = 1;
        run(2, 0);
        chk("t2_first_id", served_q[0], 0);
        chk("t2_second_id", served_q[1], 1);
        chk("t2_second_res", last_res, 8'h0F);

        // Lone req0 leaves the pointer on req1, so contention now favours req1
        req0_a = 4'h3; req0_b = 4'h5; req0_op = 4'd7; req0_valid = 1;
        run(1, 0);
        served_q.delete();
        req0_a = 4'h2; req0_b = 4'h2; req0_op = 4'd0; req0_valid = 1;
        req1_a = 4'h9; req1_b = 4'h1; req1_op = 4'd1; req1_valid = 1;
        run(2, 0);
        chk("t2_repeat_first_id", served_q[0], 1);

        // DIV from req1 with back-pressure while req0 waits
        served_q.delete();
        hcnt = 0;
        req1_a = 4'hD; req1_b = 4'h2; req1_op = 4'd3; req1_valid = 1;
        req0_a = 4'h3; req0_b = 4'h4; req0_op = 4'd0; req0_valid = 1;
        run(2, 2);
        chk("t3_first_id", served_q[0], 1);
        chk("t3_last_id", last_id, 0);

        // Illegal opcode, then MOD by zero
        req0_a = 4'h7; req0_b = 4'h3; req0_op = 4'hC; req0_valid = 1;
        run(1, 0);
        chk("t4_err", last_err, 1);
        chk("t4_res", last_res, 8'h00);
        req0_a = 4'h7; req0_b = 4'h0; req0_op = 4'd4; req0_valid = 1;
        run(1, 0);
        chk("t4_mod0_err", last_err, 1);
        chk("t4_mod0_flags", last_flags, 4'h0);

        // Reset while SUB is in EXEC
        rsp_ready = 1'b1;
        req0_a = 4'hD; req0_b = 4'h9; req0_op = 4'd1; req0_valid = 1;
        seen = 0;
        for (int i = 0; (i < 10) && !seen; i++) begin
            @(negedge clk);
            if (req0_ready) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("t5_grant_seen", seen, 1);
        @(posedge clk);
        #1;
        req0_valid = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_exec_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("t5_after_rst");
        ptr = 1'b0; last_op = 4'd0; pend.delete();
        @(posedge clk);
        #1;
        served_q.delete();
        req0_a = 4'h1; req0_b = 4'h1; req0_op = 4'd0; req0_valid = 1;
        req1_a = 4'h2; req1_b = 4'h2; req1_op = 4'd2; req1_valid = 1;
        run(2, 0);
        chk("t5_first_id", served_q[0], 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            int pat;
            pat = $urandom_range(1, 3);
            req0_a  = 4'($urandom_range(0, 15));
            req0_b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            req0_op = 4'($urandom_range(0, 11));
            req1_a  = 4'($urandom_range(0, 15));
            req1_b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            req1_op = 4'($urandom_range(0, 11));
            req0_valid = pat[0];
            req1_valid = pat[1];
            run((pat == 3) ? 2 : 1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
